// File: rtl/exs_res_buf.sv
// -----------------------------------------------------------------------------
// exs_res_buf
//
// Result buffer behind the saturating arithmetic pipeline. The pipeline cannot
// stall, so every valid result is captured if there is room. When the buffer is
// full the result is lost and counted. Results go to the consumer through a
// first-word-fall-through valid/ready interface.
//
// Optional feature macro: EXS_RES_BUF_DROP_CNT_EN
//   defined     -> saturating drop counter on drop_cnt_o
//   not defined -> no counter flops, drop_cnt_o tied to 0
//
// Ports:
//   clk_i       in   clock, all state on rising edge
//   rst_i       in   asynchronous active-high reset
//   valid_i     in   upstream result strobe (no backpressure)
//   data_i      in   signed upstream result
//   valid_o     out  head entry available
//   ready_i     in   consumer accepts head this cycle
//   data_o      out  head entry, 0 when empty
//   count_o     out  occupancy 0..DEPTH
//   full_o      out  count_o == DEPTH
//   empty_o     out  count_o == 0
//   drop_cnt_o  out  saturating count of lost inputs
// -----------------------------------------------------------------------------
module exs_res_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [CNT_WIDTH-1:0]    drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic full, empty, push, pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop  = !empty & ready_i;
    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign push = valid_i & (!full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    // Pointer difference modulo 2*DEPTH is the occupancy.
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = full;
    assign empty_o = empty;

`ifdef EXS_RES_BUF_DROP_CNT_EN
    logic                 drop;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    assign drop = valid_i & full & !pop;

    // Saturate rather than wrap so a long overflow is never under-reported.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != {CNT_WIDTH{1'b1}}))
            drop_cnt_d = drop_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign drop_cnt_o = '0;
`endif

endmodule
